// File: rtl/text_2.sv
// text_2: registered 4:1 selector for 2-bit channels A..D with an enable-qualified valid flag.
// Optional registered even-parity output Y_PAR when TEXT_2_PARITY_EN is defined.
module text_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  input  logic [1:0] S,
  input  logic       EN,
  output logic [1:0] Y,
  output logic       Y_VLD
`ifdef TEXT_2_PARITY_EN
  ,
  output logic       Y_PAR
`endif
);

  logic [1:0] w_next_y;
  logic [1:0] r_y;
  logic       r_vld;

  // EN gates the select decode, so an unknown S while disabled cannot reach Y.
  always_comb begin
    w_next_y = 2'b00;
    if (EN) begin
      case (S)
        2'd0: w_next_y = A;
        2'd1: w_next_y = B;
        2'd2: w_next_y = C;
        2'd3: w_next_y = D;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y   <= 2'b00;
      r_vld <= 1'b0;
    end else begin
      r_y   <= w_next_y;
      r_vld <= EN;
    end
  end

  assign Y     = r_y;
  assign Y_VLD = r_vld;

`ifdef TEXT_2_PARITY_EN
  logic r_par;

  // Parity is taken from the value being loaded so it lines up with Y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else begin
      r_par <= ^w_next_y;
    end
  end

  assign Y_PAR = r_par;
`endif

endmodule

// File: tb/tb_text_2.sv
// Self-checking bench for text_2: a reference model pushes {par, vld, y} to exp_q at drive
// time; each result is popped and compared one edge later. Parity is checked when TEXT_2_PARITY_EN is set.
module tb_text_2;

  logic       clk;
  logic       rst_n;
  logic [1:0] a, b, c, d, s;
  logic       en;
  logic [1:0] y;
  logic       y_vld;
  logic       y_par;

  logic [3:0] exp_q[$];
  int         checks;
  int         failures;

  text_2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .C     (c),
    .D     (d),
    .S     (s),
    .EN    (en),
    .Y     (y),
    .Y_VLD (y_vld)
`ifdef TEXT_2_PARITY_EN
    ,
    .Y_PAR (y_par)
`endif
  );

`ifndef TEXT_2_PARITY_EN
  assign y_par = 1'b0;
`endif

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference model: returns {par, vld, y}
  function automatic logic [3:0] model(input logic r, input logic e, input logic [1:0] sel,
                                       input logic [1:0] da, input logic [1:0] db,
                                       input logic [1:0] dc, input logic [1:0] dd);
    logic [1:0] ny;
    logic       nv;
    logic       np;
    ny = 2'b00;
    nv = 1'b0;
    if (r && e) begin
      if (sel == 2'd0)      ny = da;
      else if (sel == 2'd1) ny = db;
      else if (sel == 2'd2) ny = dc;
      else                  ny = dd;
    end
    if (r) nv = e;
`ifdef TEXT_2_PARITY_EN
    np = ^ny;
`else
    np = 1'b0;
`endif
    return {np, nv, ny};
  endfunction

  // Driver: apply inputs at negedge, push expectation, sample #1 after the next rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] sel,
                      input logic [1:0] da, input logic [1:0] db,
                      input logic [1:0] dc, input logic [1:0] dd);
    logic [3:0] exp;
    @(negedge clk);
    rst_n = r;
    en    = e;
    s     = sel;
    a     = da;
    b     = db;
    c     = dc;
    d     = dd;
    exp_q.push_back(model(r, e, sel, da, db, dc, dd));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {y_par, y_vld, y}, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    s     = 2'd0;
    a     = 2'b00;
    b     = 2'b01;
    c     = 2'b10;
    d     = 2'b11;

    // Reset for two edges with enable asserted: reset must win
    step("reset0", 1'b0, 1'b1, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11);
    step("reset1", 1'b0, 1'b1, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11);

    // Disabled selection gives zero
    step("en0_s2", 1'b1, 1'b0, 2'd2, 2'b00, 2'b01, 2'b10, 2'b11);

    // Walk S 0..3 (parity 0,1,1,0 when enabled)
    for (int i = 0; i < 4; i++) begin
      step($sformatf("walk_s%0d", i), 1'b1, 1'b1, 2'(i), 2'b00, 2'b01, 2'b10, 2'b11);
    end

    // EN falls while S changes: EN wins
    step("s3_en1", 1'b1, 1'b1, 2'd3, 2'b00, 2'b01, 2'b10, 2'b11);
    step("en_fall", 1'b1, 1'b0, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11);

    // Unknown select while disabled
    step("s_x_en0", 1'b1, 1'b0, 2'bxx, 2'b11, 2'b11, 2'b11, 2'b11);

    // Mid-operation reset and resume
    step("pre_rst", 1'b1, 1'b1, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11);
    step("mid_rst", 1'b0, 1'b1, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11);
    step("resume",  1'b1, 1'b1, 2'd1, 2'b00, 2'b01, 2'b10, 2'b11);

    // Data and select change together
    step("same_cyc_a", 1'b1, 1'b1, 2'd2, 2'b11, 2'b10, 2'b01, 2'b00);
    step("same_cyc_b", 1'b1, 1'b1, 2'd0, 2'b10, 2'b11, 2'b00, 2'b01);

    // Random stimulus with occasional reset
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)));
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain leftover=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_2.md
TEXT_2 -- requirements
Module: text_2

Interface
REQ-001 Parameters: none; data width is fixed at 2 bits and select width at 2 bits.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 A  input  2  data channel 0.
REQ-006 B  input  2  data channel 1.
REQ-007 C  input  2  data channel 2.
REQ-008 D  input  2  data channel 3.
REQ-009 S  input  2  channel select; 0=A, 1=B, 2=C, 3=D.
REQ-010 EN  input  1  active-high enable.
REQ-011 Y  output  2  registered selected data.
REQ-012 Y_VLD  output  1  registered copy of EN; high when Y holds selected data.
REQ-013 Y_PAR  output  1  registered even-parity of Y; present only when TEXT_2_PARITY_EN is defined.

Function
REQ-014 On each rising clk with rst_n=1 and EN=1, Y SHALL load the channel indexed by S: 00->A, 01->B, 10->C, 11->D.
REQ-015 On each rising clk with rst_n=1 and EN=0, Y SHALL load 2'b00, regardless of S and data inputs.
REQ-016 Latency from S/EN/data change to Y SHALL be exactly one clk edge; no combinational path from any input to any output.
REQ-017 Y_VLD SHALL load EN on every rising clk with rst_n=1.
REQ-018 Changing S on consecutive cycles SHALL produce a new selection every cycle; no hold-off, no glitch filtering.
REQ-019 Data inputs changing in the same cycle as S SHALL be sampled together; Y reflects the new S applied to the new data.
REQ-020 EN falling and S changing in the same cycle SHALL yield Y=00 next edge (EN has priority over S).
REQ-021 All select values 0..3 are legal; there is no out-of-range case and no default hold behaviour.
REQ-022 X or Z on S while EN=0 SHALL NOT affect Y (Y=00).

Reset
REQ-023 While rst_n=0 at a rising clk edge, Y SHALL become 2'b00, Y_VLD 0, Y_PAR 0.
REQ-024 Reset SHALL override EN and S in the same cycle.
REQ-025 Reset asserted mid-operation SHALL clear outputs on the next edge; first edge after rst_n returns high resumes normal selection with one-cycle latency.
REQ-026 Outputs before the first clk edge are undefined; no asynchronous clear.

Configuration
REQ-027 Macro TEXT_2_PARITY_EN: when defined, port Y_PAR SHALL exist and load (^next_Y) on every rising clk with rst_n=1, reset to 0.
REQ-028 When TEXT_2_PARITY_EN is undefined, Y_PAR SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-029 A=00,B=01,C=10,D=11, rst_n=0 for 2 edges -> Y=00, Y_VLD=0.
REQ-030 Same data, rst_n=1, EN=0, S=2 -> after next edge Y=00, Y_VLD=0.
REQ-031 EN=1, S stepped 0,1,2,3 one per cycle -> Y=00,01,10,11 each one edge later, Y_VLD=1.
REQ-032 EN=1, S=3, then EN=0 with S=1 same cycle -> next edge Y=00, Y_VLD=0.
REQ-033 EN=1, S=1, rst_n=0 for one edge -> Y=00; rst_n=1 -> next edge Y=01.
REQ-034 With TEXT_2_PARITY_EN: S stepped 0..3, EN=1 -> Y_PAR=0,1,1,0; without macro the build has no Y_PAR port.
